// File: rtl/fp_issue_ctrl.sv
// rtl/fp_issue_ctrl.sv - single-outstanding FP issue/writeback controller (optional sticky flags: FP_FFLAGS_EN)
module fp_issue_ctrl #(
    parameter int FLEN = 32,
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dec_valid_i,
    input  logic [3:0]      dec_op_i,
    input  logic            dec_op_mod_i,
    input  logic [2:0]      dec_rm_i,
    input  logic [4:0]      dec_waddr_i,
    input  logic            dec_fp_we_i,
    input  logic            dec_int_we_i,
    input  logic            dec_move_i,
    input  logic            dec_ls_i,
    input  logic [FLEN-1:0] opa_i,
    input  logic [FLEN-1:0] opb_i,
    input  logic [FLEN-1:0] opc_i,
    input  logic [XLEN-1:0] int_op_i,
    input  logic            flush_i,
    output logic            accept_o,
    output logic            stall_o,
    output logic            fpu_in_valid_o,
    input  logic            fpu_in_ready_i,
    output logic [3:0]      fpu_op_o,
    output logic            fpu_op_mod_o,
    output logic [2:0]      fpu_rm_o,
    output logic [FLEN-1:0] fpu_opa_o,
    output logic [FLEN-1:0] fpu_opb_o,
    output logic [FLEN-1:0] fpu_opc_o,
    input  logic            fpu_out_valid_i,
    output logic            fpu_out_ready_o,
    input  logic [FLEN-1:0] fpu_result_i,
    input  logic [4:0]      fpu_status_i,
    output logic            fp_wb_en_o,
    output logic [4:0]      fp_wb_addr_o,
    output logic [FLEN-1:0] fp_wb_data_o,
    output logic            int_wb_en_o,
    output logic [4:0]      int_wb_addr_o,
    output logic [XLEN-1:0] int_wb_data_o,
    input  logic            fflags_clr_i,
    output logic [4:0]      fflags_o
);

    localparam logic [3:0] OP_I2F = 4'd12;

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WB} state_t;

    state_t          state;
    logic            fp_we_q;
    logic            int_we_q;
    logic            move_q;
    logic            drop_q;
    logic [4:0]      waddr_q;
    logic [FLEN-1:0] result_q;
    logic            wb_fire;

    assign accept_o        = (state == IDLE) & dec_valid_i;
    assign stall_o         = dec_valid_i & ~accept_o;
    assign fpu_in_valid_o  = (state == ISSUE);
    assign fpu_out_ready_o = (state == EXEC);

    assign wb_fire       = (state == WB) & ~flush_i;
    assign fp_wb_en_o    = wb_fire & fp_we_q;
    assign int_wb_en_o   = wb_fire & int_we_q & ~fp_we_q;
    assign fp_wb_addr_o  = waddr_q;
    assign int_wb_addr_o = waddr_q;
    assign fp_wb_data_o  = result_q;
    assign int_wb_data_o = result_q[XLEN-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            fp_we_q      <= 1'b0;
            int_we_q     <= 1'b0;
            move_q       <= 1'b0;
            drop_q       <= 1'b0;
            waddr_q      <= '0;
            result_q     <= '0;
            fpu_op_o     <= '0;
            fpu_op_mod_o <= 1'b0;
            fpu_rm_o     <= '0;
            fpu_opa_o    <= '0;
            fpu_opb_o    <= '0;
            fpu_opc_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_valid_i && !dec_ls_i) begin
                        waddr_q  <= dec_waddr_i;
                        fp_we_q  <= dec_fp_we_i;
                        int_we_q <= dec_int_we_i;
                        move_q   <= dec_move_i;
                        drop_q   <= 1'b0;
                        if (dec_move_i) begin
                            result_q <= FLEN'(int_op_i);
                            state    <= WB;
                        end else begin
                            fpu_op_o     <= dec_op_i;
                            fpu_op_mod_o <= dec_op_mod_i;
                            fpu_rm_o     <= dec_rm_i;
                            fpu_opa_o    <= (dec_op_i == OP_I2F) ? FLEN'(int_op_i) : opa_i;
                            fpu_opb_o    <= opb_i;
                            fpu_opc_o    <= opc_i;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // A flush racing the input handshake still owes FPnew a result slot.
                    if (fpu_in_ready_i) begin
                        drop_q <= flush_i;
                        state  <= EXEC;
                    end else if (flush_i) begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    if (flush_i) drop_q <= 1'b1;
                    if (fpu_out_valid_i) begin
                        if (drop_q || flush_i) begin
                            state <= IDLE;
                        end else begin
                            result_q <= fpu_result_i;
                            state    <= WB;
                        end
                    end
                end
                WB: state <= IDLE;
            endcase
        end
    end

`ifdef FP_FFLAGS_EN
    logic [4:0] status_q;
    logic [4:0] fflags_q;

    // A clear coinciding with an update drops the old flags but keeps the new status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
            fflags_q <= '0;
        end else begin
            if (state == EXEC && fpu_out_valid_i) status_q <= fpu_status_i;
            if (wb_fire && !move_q) begin
                fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | status_q;
            end else if (fflags_clr_i) begin
                fflags_q <= '0;
            end
        end
    end

    assign fflags_o = fflags_q;
`else
    logic unused_fflags;
    assign unused_fflags = ^{fpu_status_i, fflags_clr_i, move_q};
    assign fflags_o      = '0;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb/tb_fp_issue_ctrl.sv - directed self-checking bench for fp_issue_ctrl
module tb_fp_issue_ctrl;

`ifdef FP_FFLAGS_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_op_mod, dec_fp_we, dec_int_we, dec_move, dec_ls;
    logic [3:0]  dec_op;
    logic [2:0]  dec_rm;
    logic [4:0]  dec_waddr;
    logic [31:0] opa, opb, opc, int_op;
    logic        flush, accept, stall;
    logic        fpu_in_valid, fpu_in_ready, fpu_op_mod;
    logic [3:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_opa, fpu_opb, fpu_opc;
    logic        fpu_out_valid, fpu_out_ready;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_status;
    logic        fp_wb_en, int_wb_en;
    logic [4:0]  fp_wb_addr, int_wb_addr;
    logic [31:0] fp_wb_data, int_wb_data;
    logic        fflags_clr;
    logic [4:0]  fflags;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_issue_ctrl #(.FLEN(32), .XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .dec_valid_i(dec_valid), .dec_op_i(dec_op), .dec_op_mod_i(dec_op_mod), .dec_rm_i(dec_rm),
        .dec_waddr_i(dec_waddr), .dec_fp_we_i(dec_fp_we), .dec_int_we_i(dec_int_we),
        .dec_move_i(dec_move), .dec_ls_i(dec_ls),
        .opa_i(opa), .opb_i(opb), .opc_i(opc), .int_op_i(int_op), .flush_i(flush),
        .accept_o(accept), .stall_o(stall),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod), .fpu_rm_o(fpu_rm),
        .fpu_opa_o(fpu_opa), .fpu_opb_o(fpu_opb), .fpu_opc_o(fpu_opc),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
        .fp_wb_en_o(fp_wb_en), .fp_wb_addr_o(fp_wb_addr), .fp_wb_data_o(fp_wb_data),
        .int_wb_en_o(int_wb_en), .int_wb_addr_o(int_wb_addr), .int_wb_data_o(int_wb_data),
        .fflags_clr_i(fflags_clr), .fflags_o(fflags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_op = 4'd0; dec_op_mod = 1'b0; dec_rm = 3'd0; dec_waddr = 5'd0;
        dec_fp_we = 1'b0; dec_int_we = 1'b0; dec_move = 1'b0; dec_ls = 1'b0;
        opa = 32'h0; opb = 32'h0; opc = 32'h0; int_op = 32'h0; flush = 1'b0;
        fpu_in_ready = 1'b1; fpu_out_valid = 1'b0; fpu_result = 32'h0; fpu_status = 5'h0;
        fflags_clr = 1'b0;
    endtask

    // Drives one FP-target op through issue/exec/wb with a 0-latency FPnew; returns in IDLE.
    task automatic run_fpu_op(input logic [3:0] op, input logic [4:0] status, input logic clr_in_wb);
        dec_valid = 1'b1; dec_op = op; dec_fp_we = 1'b1; dec_waddr = 5'd1; fpu_in_ready = 1'b1;
        step();
        dec_valid = 1'b0;
        step();
        fpu_out_valid = 1'b1; fpu_result = 32'h3F800000; fpu_status = status;
        step();
        fpu_out_valid = 1'b0; fpu_status = 5'h0; fflags_clr = clr_in_wb;
        step();
        fflags_clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        total++; if (accept !== 1'b0) begin bad++; $display("FAIL rst_accept: got %b want 0", accept); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (fpu_in_valid !== 1'b0) begin bad++; $display("FAIL rst_in_valid: got %b want 0", fpu_in_valid); end
        total++; if (fpu_out_ready !== 1'b0) begin bad++; $display("FAIL rst_out_ready: got %b want 0", fpu_out_ready); end
        total++; if ({fp_wb_en, int_wb_en} !== 2'b00) begin bad++; $display("FAIL rst_wb_en: got %b want 00", {fp_wb_en, int_wb_en}); end
        total++; if (fflags !== 5'h0) begin bad++; $display("FAIL rst_fflags: got %h want 00", fflags); end
        total++; if ({fpu_opa, fp_wb_data, fp_wb_addr} !== 69'h0) begin bad++; $display("FAIL rst_regs: got %h want 0", {fpu_opa, fp_wb_data, fp_wb_addr}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fadd();
        dec_valid = 1'b1; dec_op = 4'd2; dec_fp_we = 1'b1; dec_waddr = 5'd5;
        opa = 32'h3F800000; opb = 32'h40000000; fpu_in_ready = 1'b1;
        #1;
        total++; if ({accept, stall, fpu_in_valid} !== 3'b100) begin bad++; $display("FAIL fadd_accept: got %b want 100", {accept, stall, fpu_in_valid}); end
        step();
        opa = 32'h0; opb = 32'h0;
        #1;
        total++; if ({fpu_in_valid, accept, stall} !== 3'b101) begin bad++; $display("FAIL fadd_issue: got %b want 101", {fpu_in_valid, accept, stall}); end
        total++; if ({fpu_op, fpu_opa, fpu_opb} !== {4'd2, 32'h3F800000, 32'h40000000}) begin bad++; $display("FAIL fadd_fields: got %h want 23f80000040000000", {fpu_op, fpu_opa, fpu_opb}); end
        step();
        #1;
        total++; if ({fpu_in_valid, fpu_out_ready, stall} !== 3'b011) begin bad++; $display("FAIL fadd_exec: got %b want 011", {fpu_in_valid, fpu_out_ready, stall}); end
        step();
        #1;
        total++; if ({fp_wb_en, fpu_out_ready} !== 2'b01) begin bad++; $display("FAIL fadd_wait: got %b want 01", {fp_wb_en, fpu_out_ready}); end
        step();
        fpu_out_valid = 1'b1; fpu_result = 32'h40400000;
        #1;
        total++; if (fp_wb_en !== 1'b0) begin bad++; $display("FAIL fadd_no_comb_wb: got %b want 0", fp_wb_en); end
        step();
        fpu_out_valid = 1'b0; fpu_result = 32'h0;
        #1;
        total++; if ({fp_wb_en, int_wb_en, stall, fpu_in_valid} !== 4'b1010) begin bad++; $display("FAIL fadd_wb_en: got %b want 1010", {fp_wb_en, int_wb_en, stall, fpu_in_valid}); end
        total++; if ({fp_wb_addr, fp_wb_data} !== {5'd5, 32'h40400000}) begin bad++; $display("FAIL fadd_wb_data: got %h want 0540400000", {fp_wb_addr, fp_wb_data}); end
        step();
        dec_ls = 1'b1;
        #1;
        total++; if ({accept, stall, fp_wb_en} !== 3'b100) begin bad++; $display("FAIL fadd_next_accept: got %b want 100", {accept, stall, fp_wb_en}); end
        step();
        #1;
        total++; if ({fpu_in_valid, fpu_out_ready, fp_wb_en} !== 3'b000) begin bad++; $display("FAIL ls_stays_idle: got %b want 000", {fpu_in_valid, fpu_out_ready, fp_wb_en}); end
        idle_inputs();
        step();
    endtask

    task automatic test_fcvt();
        dec_valid = 1'b1; dec_op = 4'd11; dec_int_we = 1'b1; dec_waddr = 5'd10; opa = 32'h40E00000;
        #1;
        total++; if (accept !== 1'b1) begin bad++; $display("FAIL fcvt_accept: got %b want 1", accept); end
        step();
        dec_valid = 1'b0;
        #1;
        total++; if (fpu_in_valid !== 1'b1) begin bad++; $display("FAIL fcvt_issue: got %b want 1", fpu_in_valid); end
        step();
        fpu_out_valid = 1'b1; fpu_result = 32'h00000007;
        #1;
        total++; if ({fpu_out_ready, int_wb_en} !== 2'b10) begin bad++; $display("FAIL fcvt_exec: got %b want 10", {fpu_out_ready, int_wb_en}); end
        step();
        fpu_out_valid = 1'b0; fpu_result = 32'h0; dec_valid = 1'b1; dec_ls = 1'b1;
        #1;
        total++; if ({int_wb_en, fp_wb_en, accept} !== 3'b100) begin bad++; $display("FAIL fcvt_wb_en: got %b want 100", {int_wb_en, fp_wb_en, accept}); end
        total++; if ({int_wb_addr, int_wb_data} !== {5'd10, 32'h7}) begin bad++; $display("FAIL fcvt_wb_data: got %h want 0a00000007", {int_wb_addr, int_wb_data}); end
        step();
        #1;
        total++; if ({accept, int_wb_en} !== 2'b10) begin bad++; $display("FAIL fcvt_accept4: got %b want 10", {accept, int_wb_en}); end
        idle_inputs();
        step();
    endtask

    task automatic test_i2f();
        dec_valid = 1'b1; dec_op = 4'd12; dec_fp_we = 1'b1; dec_waddr = 5'd2;
        opa = 32'hFFFFFFFF; int_op = 32'h5;
        step();
        dec_valid = 1'b0; int_op = 32'h0;
        #1;
        total++; if ({fpu_op, fpu_opa} !== {4'd12, 32'h5}) begin bad++; $display("FAIL i2f_opa: got %h want c00000005", {fpu_op, fpu_opa}); end
        step();
        fpu_out_valid = 1'b1; fpu_result = 32'h40A00000;
        step();
        fpu_out_valid = 1'b0;
        #1;
        total++; if ({fp_wb_en, fp_wb_data} !== {1'b1, 32'h40A00000}) begin bad++; $display("FAIL i2f_wb: got %h want 140a00000", {fp_wb_en, fp_wb_data}); end
        idle_inputs();
        step();
    endtask

    task automatic test_move();
        dec_valid = 1'b1; dec_move = 1'b1; dec_fp_we = 1'b1; dec_waddr = 5'd7; int_op = 32'hDEADBEEF;
        #1;
        total++; if (accept !== 1'b1) begin bad++; $display("FAIL mv_accept: got %b want 1", accept); end
        step();
        idle_inputs();
        #1;
        total++; if ({fp_wb_en, int_wb_en, fpu_in_valid} !== 3'b100) begin bad++; $display("FAIL mv_wb_en: got %b want 100", {fp_wb_en, int_wb_en, fpu_in_valid}); end
        total++; if ({fp_wb_addr, fp_wb_data} !== {5'd7, 32'hDEADBEEF}) begin bad++; $display("FAIL mv_wb_data: got %h want 07deadbeef", {fp_wb_addr, fp_wb_data}); end
        step();
        #1;
        total++; if ({fp_wb_en, fpu_in_valid} !== 2'b00) begin bad++; $display("FAIL mv_done: got %b want 00", {fp_wb_en, fpu_in_valid}); end
        step();
    endtask

    task automatic test_in_ready_stall();
        dec_valid = 1'b1; dec_op = 4'd3; dec_op_mod = 1'b1; dec_rm = 3'd3; dec_fp_we = 1'b1; dec_waddr = 5'd3;
        opa = 32'h11111111; opb = 32'h22222222; opc = 32'h33333333; fpu_in_ready = 1'b0;
        step();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            fpu_in_ready = (i == 5);
            #1;
            total++; if ({fpu_in_valid, fpu_op, fpu_op_mod, fpu_rm} !== {1'b1, 4'd3, 1'b1, 3'd3}) begin bad++; $display("FAIL hold_ctrl[%0d]: got %h want 1 3 1 3", i, {fpu_in_valid, fpu_op, fpu_op_mod, fpu_rm}); end
            total++; if ({fpu_opa, fpu_opb, fpu_opc} !== {32'h11111111, 32'h22222222, 32'h33333333}) begin bad++; $display("FAIL hold_ops[%0d]: got %h want 111111112222222233333333", i, {fpu_opa, fpu_opb, fpu_opc}); end
            step();
        end
        total++; if ({fpu_in_valid, fpu_out_ready} !== 2'b01) begin bad++; $display("FAIL hold_exec: got %b want 01", {fpu_in_valid, fpu_out_ready}); end
        fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        #1;
        total++; if (fp_wb_en !== 1'b1) begin bad++; $display("FAIL hold_wb: got %b want 1", fp_wb_en); end
        step();
    endtask

    task automatic test_flush_exec(input logic [4:0] exp_ff);
        dec_valid = 1'b1; dec_op = 4'd4; dec_fp_we = 1'b1; dec_waddr = 5'd9;
        step();
        dec_valid = 1'b0;
        step();
        flush = 1'b1;
        #1;
        total++; if (fpu_out_ready !== 1'b1) begin bad++; $display("FAIL fle_ready: got %b want 1", fpu_out_ready); end
        step();
        flush = 1'b0;
        #1;
        total++; if (fpu_out_ready !== 1'b1) begin bad++; $display("FAIL fle_ready_held: got %b want 1", fpu_out_ready); end
        step();
        fpu_out_valid = 1'b1; fpu_result = 32'h12345678; fpu_status = 5'h10;
        step();
        fpu_out_valid = 1'b0; fpu_status = 5'h0; dec_valid = 1'b1; dec_ls = 1'b1;
        #1;
        total++; if ({fp_wb_en, int_wb_en, fpu_out_ready, accept} !== 4'b0001) begin bad++; $display("FAIL fle_no_wb: got %b want 0001", {fp_wb_en, int_wb_en, fpu_out_ready, accept}); end
        step();
        idle_inputs();
        #1;
        total++; if (fflags !== exp_ff) begin bad++; $display("FAIL fle_fflags: got %h want %h", fflags, exp_ff); end
        step();
    endtask

    task automatic test_flush_issue_wb();
        dec_valid = 1'b1; dec_op = 4'd2; dec_fp_we = 1'b1; fpu_in_ready = 1'b0;
        step();
        dec_valid = 1'b0; flush = 1'b1;
        #1;
        total++; if (fpu_in_valid !== 1'b1) begin bad++; $display("FAIL fli_valid: got %b want 1", fpu_in_valid); end
        step();
        flush = 1'b0; dec_valid = 1'b1; dec_ls = 1'b1;
        #1;
        total++; if ({fpu_in_valid, accept} !== 2'b01) begin bad++; $display("FAIL fli_idle: got %b want 01", {fpu_in_valid, accept}); end
        step();
        idle_inputs();
        dec_valid = 1'b1; dec_move = 1'b1; dec_fp_we = 1'b1; dec_waddr = 5'd4; int_op = 32'hCAFEF00D;
        step();
        idle_inputs();
        flush = 1'b1;
        #1;
        total++; if (fp_wb_en !== 1'b0) begin bad++; $display("FAIL flw_suppress: got %b want 0", fp_wb_en); end
        step();
        flush = 1'b0;
        #1;
        total++; if (fp_wb_en !== 1'b0) begin bad++; $display("FAIL flw_after: got %b want 0", fp_wb_en); end
        step();
    endtask

    task automatic test_fflags();
        run_fpu_op(4'd4, 5'h08, 1'b0);
        total++; if (fflags !== (FF_EN ? 5'h08 : 5'h00)) begin bad++; $display("FAIL ff_dz: got %h want %h", fflags, FF_EN ? 5'h08 : 5'h00); end
        run_fpu_op(4'd2, 5'h01, 1'b0);
        total++; if (fflags !== (FF_EN ? 5'h09 : 5'h00)) begin bad++; $display("FAIL ff_nx: got %h want %h", fflags, FF_EN ? 5'h09 : 5'h00); end
        dec_valid = 1'b1; dec_move = 1'b1; dec_fp_we = 1'b1; int_op = 32'h1; fpu_status = 5'h1F;
        step();
        idle_inputs();
        step();
        total++; if (fflags !== (FF_EN ? 5'h09 : 5'h00)) begin bad++; $display("FAIL ff_move: got %h want %h", fflags, FF_EN ? 5'h09 : 5'h00); end
        test_flush_exec(FF_EN ? 5'h09 : 5'h00);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        #1;
        total++; if (fflags !== 5'h00) begin bad++; $display("FAIL ff_clr: got %h want 00", fflags); end
        run_fpu_op(4'd3, 5'h02, 1'b0);
        total++; if (fflags !== (FF_EN ? 5'h02 : 5'h00)) begin bad++; $display("FAIL ff_uf: got %h want %h", fflags, FF_EN ? 5'h02 : 5'h00); end
        run_fpu_op(4'd3, 5'h04, 1'b1);
        total++; if (fflags !== (FF_EN ? 5'h04 : 5'h00)) begin bad++; $display("FAIL ff_clr_vs_wb: got %h want %h", fflags, FF_EN ? 5'h04 : 5'h00); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fadd();
        test_fcvt();
        test_i2f();
        test_move();
        test_in_ready_stall();
        test_flush_exec(5'h00);
        test_flush_issue_wb();
        test_fflags();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
